// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gate-window frequency and peak meter with adaptive hysteresis threshold
module freq_meter #(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned GATE_CYCLES = CLK_FREQ,
    parameter int unsigned HYST        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [5:0]  sample,
    input  logic        sample_valid,
    output logic [31:0] freq,
    output logic [5:0]  amp_max,
    output logic [5:0]  amp_min,
    output logic        done,
    output logic        low_amp,
    output logic        ovf
);

    typedef enum logic {
        ST_CAL  = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [6:0]  HYST7     = 7'(HYST);
    localparam logic [6:0]  SPAN_MIN  = 7'(2 * HYST);
    localparam logic [31:0] EDGE_SAT  = 32'hFFFF_FFFF;

    // input stage
    logic [5:0]  sample_q, sample_d;
    logic        valid_q, valid_d;

    // window state
    state_t      state_q, state_d;
    logic [31:0] gate_q, gate_d;
    logic [31:0] edge_q, edge_d;
    logic        armed_q, armed_d;
    logic [5:0]  win_max_q, win_max_d;
    logic [5:0]  win_min_q, win_min_d;
    logic        win_ovf_q, win_ovf_d;
    logic        win_seen_q, win_seen_d;
    logic [5:0]  thr_q, thr_d;

    // registered results
    logic [31:0] freq_q, freq_d;
    logic [5:0]  amp_max_q, amp_max_d;
    logic [5:0]  amp_min_q, amp_min_d;
    logic        done_q, done_d;
    logic        low_amp_q, low_amp_d;
    logic        ovf_q, ovf_d;

    // hysteresis band around the current threshold, clamped to the 6-bit range
    logic [6:0]  thr7, lo7, hi7;
    logic [5:0]  lo, hi;
    assign thr7 = {1'b0, thr_q};
    assign lo7  = thr7 - HYST7;
    assign hi7  = thr7 + HYST7;
    assign lo   = (thr7 < HYST7) ? 6'd0 : lo7[5:0];
    assign hi   = (hi7 > 7'd63) ? 6'd63 : hi7[5:0];

    // this cycle's contribution folded into the running window statistics
    logic        arm_hit, edge_hit, edge_sat, cur_ovf, cur_seen, cur_low, win_end;
    logic [31:0] cur_edge;
    logic [5:0]  cur_max, cur_min, cur_span;
    logic [6:0]  mid_sum;
    assign arm_hit  = valid_q && (sample_q <= lo);
    assign edge_hit = valid_q && armed_q && (sample_q >= hi);
    assign edge_sat = (edge_q == EDGE_SAT);
    assign cur_edge = (edge_hit && !edge_sat) ? edge_q + 32'd1 : edge_q;
    assign cur_ovf  = win_ovf_q | (edge_hit & edge_sat);
    assign cur_max  = (valid_q && (sample_q > win_max_q)) ? sample_q : win_max_q;
    assign cur_min  = (valid_q && (sample_q < win_min_q)) ? sample_q : win_min_q;
    assign cur_seen = win_seen_q | valid_q;
    assign mid_sum  = {1'b0, cur_max} + {1'b0, cur_min};
    assign cur_span = cur_max - cur_min;
    // an empty window reports max=0/min=63, so it must be flagged explicitly
    assign cur_low  = !cur_seen || ({1'b0, cur_span} < SPAN_MIN);
    assign win_end  = (gate_q == GATE_LAST);

    // next-state: gate timing, crossing detection, CAL/MEAS sequencing and result latch
    always_comb begin
        sample_d   = sample;
        valid_d    = sample_valid;
        state_d    = state_q;
        gate_d     = gate_q;
        edge_d     = edge_q;
        armed_d    = armed_q;
        win_max_d  = win_max_q;
        win_min_d  = win_min_q;
        win_ovf_d  = win_ovf_q;
        win_seen_d = win_seen_q;
        thr_d      = thr_q;
        freq_d     = freq_q;
        amp_max_d  = amp_max_q;
        amp_min_d  = amp_min_q;
        done_d     = 1'b0;
        low_amp_d  = low_amp_q;
        ovf_d      = ovf_q;

        if (!en) begin
            state_d    = ST_CAL;
            gate_d     = 32'd0;
            edge_d     = 32'd0;
            armed_d    = 1'b0;
            win_max_d  = 6'd0;
            win_min_d  = 6'd63;
            win_ovf_d  = 1'b0;
            win_seen_d = 1'b0;
        end else begin
            gate_d = win_end ? 32'd0 : gate_q + 32'd1;

            // armed survives window boundaries so a crossing split across them is kept
            if (arm_hit) begin
                armed_d = 1'b1;
            end else if (edge_hit) begin
                armed_d = 1'b0;
            end

            if (win_end) begin
                if (cur_seen) begin
                    thr_d = mid_sum[6:1];
                end
                if (state_q == ST_MEAS) begin
                    freq_d    = cur_edge;
                    amp_max_d = cur_max;
                    amp_min_d = cur_min;
                    low_amp_d = cur_low;
                    ovf_d     = cur_ovf;
                    done_d    = 1'b1;
                end
                state_d    = ST_MEAS;
                edge_d     = 32'd0;
                win_max_d  = 6'd0;
                win_min_d  = 6'd63;
                win_ovf_d  = 1'b0;
                win_seen_d = 1'b0;
            end else begin
                edge_d     = cur_edge;
                win_max_d  = cur_max;
                win_min_d  = cur_min;
                win_ovf_d  = cur_ovf;
                win_seen_d = cur_seen;
            end
        end
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q   <= 6'd0;
            valid_q    <= 1'b0;
            state_q    <= ST_CAL;
            gate_q     <= 32'd0;
            edge_q     <= 32'd0;
            armed_q    <= 1'b0;
            win_max_q  <= 6'd0;
            win_min_q  <= 6'd63;
            win_ovf_q  <= 1'b0;
            win_seen_q <= 1'b0;
            thr_q      <= 6'd32;
            freq_q     <= 32'd0;
            amp_max_q  <= 6'd0;
            amp_min_q  <= 6'd0;
            done_q     <= 1'b0;
            low_amp_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            armed_q    <= armed_d;
            win_max_q  <= win_max_d;
            win_min_q  <= win_min_d;
            win_ovf_q  <= win_ovf_d;
            win_seen_q <= win_seen_d;
            thr_q      <= thr_d;
            freq_q     <= freq_d;
            amp_max_q  <= amp_max_d;
            amp_min_q  <= amp_min_d;
            done_q     <= done_d;
            low_amp_q  <= low_amp_d;
            ovf_q      <= ovf_d;
        end
    end

    assign freq    = freq_q;
    assign amp_max = amp_max_q;
    assign amp_min = amp_min_q;
    assign done    = done_q;
    assign low_amp = low_amp_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter
module tb_freq_meter;

    localparam int GATE = 1000;
    localparam int HYST = 4;

    localparam int K_SQ       = 0;  // 0/63 square, period 100, low half first
    localparam int K_SINE     = 1;  // 10..50 sine, period 40
    localparam int K_NOISE    = 2;  // 30/33 toggling every clk
    localparam int K_LASTEDGE = 3;  // 0 all window, 63 on the last gate sample only
    localparam int K_HIGH     = 4;  // constant 63
    localparam int K_NOVALID  = 5;  // sample_valid low all window

    localparam int SINE_TAB [40] = '{30, 33, 36, 39, 42, 44, 46, 48, 49, 50,
                                     50, 50, 49, 48, 46, 44, 42, 39, 36, 33,
                                     30, 27, 24, 21, 18, 16, 14, 12, 11, 10,
                                     10, 10, 11, 12, 14, 16, 18, 21, 24, 27};

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [5:0]  sample;
    logic        sample_valid;
    logic [31:0] freq;
    logic [5:0]  amp_max;
    logic [5:0]  amp_min;
    logic        done;
    logic        low_amp;
    logic        ovf;

    freq_meter #(
        .CLK_FREQ    (GATE),
        .GATE_CYCLES (GATE),
        .HYST        (HYST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample       (sample),
        .sample_valid (sample_valid),
        .freq         (freq),
        .amp_max      (amp_max),
        .amp_min      (amp_min),
        .done         (done),
        .low_amp      (low_amp),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          exp_cyc;
        logic [31:0] freq;
        logic [5:0]  amax;
        logic [5:0]  amin;
        logic        low;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   g1       = 0;  // posedge count at the negedge of segment cycle 1

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: every done pulse pops one expectation, including its arrival cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.exp_cyc);
                chk("freq", freq, e.freq);
                chk("amp_max", 32'(amp_max), 32'(e.amax));
                chk("amp_min", 32'(amp_min), 32'(e.amin));
                chk("low_amp", 32'(low_amp), 32'(e.low));
                chk("ovf", 32'(ovf), 32'd0);
            end
        end
    end

    task automatic drive(input int kind, input int n);
        sample_valid = 1'b1;
        case (kind)
            K_SQ:       sample = ((n % 100) < 50) ? 6'd0 : 6'd63;
            K_SINE:     sample = 6'(SINE_TAB[n % 40]);
            K_NOISE:    sample = ((n % 2) == 0) ? 6'd30 : 6'd33;
            K_LASTEDGE: sample = ((n % GATE) == GATE - 1) ? 6'd63 : 6'd0;
            K_HIGH:     sample = 6'd63;
            default: begin
                sample       = 6'd0;
                sample_valid = 1'b0;
            end
        endcase
    endtask

    // Window k of a segment is judged on the samples driven in segment cycles
    // 1000k..1000k+999 (one register stage ahead of the gate counter); its done
    // is seen at posedge count g1 + 1000*(k+1), i.e. segment cycle 1000*(k+1)+1.
    task automatic run_win(input int kind, input int k, input int ef, input int emax,
                           input int emin, input logic elow);
        exp_t e;
        for (int off = 0; off < GATE; off++) begin
            @(negedge clk);
            drive(kind, k * GATE + off);
            if (k == 0 && off == 1) begin
                rst = 1'b0;
                en  = 1'b1;
                g1  = cyc;
            end
        end
        if (k > 0) begin
            e.exp_cyc = g1 + GATE * (k + 1);
            e.freq    = 32'(ef);
            e.amax    = 6'(emax);
            e.amin    = 6'(emin);
            e.low     = elow;
            sb.push_back(e);
        end
    endtask

    task automatic run_partial(input int kind, input int k, input int cnt);
        for (int off = 0; off < cnt; off++) begin
            @(negedge clk);
            drive(kind, k * GATE + off);
        end
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        sample       = 6'd0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_freq", freq, 32'd0);
        chk("rst_amp_max", 32'(amp_max), 32'd0);
        chk("rst_amp_min", 32'(amp_min), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_low_amp", 32'(low_amp), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // CAL on square -> thr 31; first done at segment cycle 2001
        run_win(K_SQ,       0,  0,  0,  0, 1'b0);
        run_win(K_SQ,       1, 10, 63,  0, 1'b0);
        run_win(K_SQ,       2, 10, 63,  0, 1'b0);
        // first sine window starts disarmed after the square high half: 24 edges
        run_win(K_SINE,     3, 24, 50, 10, 1'b0);
        run_win(K_SINE,     4, 25, 50, 10, 1'b0);
        run_win(K_SINE,     5, 25, 50, 10, 1'b0);
        // noise inside the hysteresis band never crosses
        run_win(K_NOISE,    6,  0, 33, 30, 1'b1);
        run_win(K_NOISE,    7,  0, 33, 30, 1'b1);
        // crossing on the last gate cycle belongs to the ending window only
        run_win(K_LASTEDGE, 8,  1, 63,  0, 1'b0);
        run_win(K_HIGH,     9,  0, 63, 63, 1'b1);
        // thr 63 clamps hi to 63; the square still reaches it
        run_win(K_SQ,      10, 10, 63,  0, 1'b0);
        run_win(K_SQ,      11, 10, 63,  0, 1'b0);

        // drop en mid-window for 5 clk: outputs hold, no done until CAL+MEAS again
        run_partial(K_SQ, 12, 500);
        @(negedge clk);
        en = 1'b0;
        drive(K_SQ, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(K_SQ, 0);
            chk("hold_freq", freq, 32'd10);
            chk("hold_amp_max", 32'(amp_max), 32'd63);
            chk("hold_low_amp", 32'(low_amp), 32'd0);
        end
        run_win(K_SQ, 0,  0,  0, 0, 1'b0);
        run_win(K_SQ, 1, 10, 63, 0, 1'b0);

        // asynchronous reset mid-window, en stays high
        run_partial(K_SQ, 2, 300);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_freq", freq, 32'd0);
        chk("arst_amp_max", 32'(amp_max), 32'd0);
        chk("arst_amp_min", 32'(amp_min), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_low_amp", 32'(low_amp), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        run_win(K_SQ,      0,  0,  0,  0, 1'b0);
        run_win(K_SQ,      1, 10, 63,  0, 1'b0);
        // no valid samples: empty-window report
        run_win(K_NOVALID, 2,  0,  0, 63, 1'b1);
        run_win(K_SQ,      3, 10, 63,  0, 1'b0);

        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL done_timeout: %0d results still pending, expected 0", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
